// File: rtl/cmos_capture_ctrl.sv
// Frame-level capture controller for a 16-bit CMOS pixel stream: arm, align, forward, check.
// Define CMOS_CAP_CROP_EN to forward only the CROP_* window instead of the full line/frame.
module cmos_capture_ctrl #(
  parameter int unsigned H_ACT   = 640,
  parameter int unsigned V_ACT   = 480,
  parameter int unsigned CROP_X0 = 0,
  parameter int unsigned CROP_Y0 = 0,
  parameter int unsigned CROP_W  = 320,
  parameter int unsigned CROP_H  = 240
) (
  input  logic        cam_pclk,
  input  logic        rst_n,
  input  logic        frame_vsync,
  input  logic        frame_href,
  input  logic        frame_valid,
  input  logic [15:0] frame_data,
  input  logic        cap_start,
  input  logic        cap_stop,
  input  logic        cap_single,
  input  logic [3:0]  frame_skip,
  output logic        out_valid,
  output logic [15:0] out_data,
  output logic        out_sof,
  output logic        out_eol,
  output logic        frame_done,
  output logic        busy,
  output logic [15:0] frame_cnt,
  output logic        err_line,
  output logic        err_frame
);

  typedef enum logic [1:0] {StIdle, StArm, StCapt, StSkip} state_e;

  localparam logic [11:0] HAct   = 12'(H_ACT);
  localparam logic [11:0] VAct   = 12'(V_ACT);
  localparam logic [11:0] CntMax = 12'hfff;
`ifdef CMOS_CAP_CROP_EN
  localparam logic [12:0] XLo     = 13'(CROP_X0);
  localparam logic [12:0] XHi     = 13'(CROP_X0 + CROP_W);
  localparam logic [12:0] YLo     = 13'(CROP_Y0);
  localparam logic [12:0] YHi     = 13'(CROP_Y0 + CROP_H);
  localparam logic [11:0] LastCol = 12'(CROP_X0 + CROP_W - 1);
`else
  localparam logic [11:0] LastCol = 12'(H_ACT - 1);
`endif

  state_e      state_q, state_d;
  logic        vsync_q, href_q;
  logic [11:0] x_cnt_q, x_cnt_d, y_cnt_q, y_cnt_d;
  logic        single_q, single_d;
  logic [3:0]  skip_q, skip_d, skip_cnt_q, skip_cnt_d;
  logic        stop_pend_q, stop_pend_d, sof_pend_q, sof_pend_d;
  logic        out_valid_q, out_valid_d, out_sof_q, out_sof_d, out_eol_q, out_eol_d;
  logic [15:0] out_data_q, out_data_d, frame_cnt_q, frame_cnt_d;
  logic        frame_done_q, frame_done_d;
  logic        err_line_q, err_line_d, err_frame_q, err_frame_d;
  logic        vs_rise, href_fall, in_win, fwd, new_frame;
`ifdef CMOS_CAP_CROP_EN
  logic [11:0] y_pix;
`endif

  assign vs_rise   = frame_vsync & ~vsync_q;
  assign href_fall = href_q & ~frame_href;

  always_comb begin
    state_d      = state_q;
    single_d     = single_q;
    skip_d       = skip_q;
    skip_cnt_d   = skip_cnt_q;
    stop_pend_d  = stop_pend_q;
    frame_cnt_d  = frame_cnt_q;
    err_line_d   = err_line_q;
    err_frame_d  = err_frame_q;
    frame_done_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (cap_start && !cap_stop) begin
          state_d     = StArm;
          single_d    = cap_single;
          skip_d      = frame_skip;
          stop_pend_d = 1'b0;
          frame_cnt_d = '0;
          err_line_d  = 1'b0;
          err_frame_d = 1'b0;
        end
      end
      StArm: begin
        if (cap_stop) state_d = StIdle;
        else if (vs_rise) state_d = StCapt;
      end
      StCapt: begin
        if (cap_stop) stop_pend_d = 1'b1;
        if (vs_rise) begin
          frame_done_d = 1'b1;
          frame_cnt_d  = frame_cnt_q + 16'd1;
          if (y_cnt_q != VAct) err_frame_d = 1'b1;
          // A stop arriving on the closing edge is treated like an earlier one.
          if (single_q || stop_pend_q || cap_stop) begin
            state_d     = StIdle;
            stop_pend_d = 1'b0;
          end else if (skip_q == 4'd0) begin
            state_d = StCapt;
          end else begin
            state_d    = StSkip;
            skip_cnt_d = skip_q - 4'd1;
          end
        end
      end
      StSkip: begin
        if (cap_stop) begin
          state_d = StIdle;
        end else if (vs_rise) begin
          if (skip_cnt_q == 4'd0) state_d = StCapt;
          else skip_cnt_d = skip_cnt_q - 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    if ((state_q != StIdle) && href_fall && (x_cnt_q != HAct)) err_line_d = 1'b1;
  end

  always_comb begin
    x_cnt_d = x_cnt_q;
    y_cnt_d = y_cnt_q;
    if (href_fall) x_cnt_d = '0;
    else if (frame_valid && (x_cnt_q != CntMax)) x_cnt_d = x_cnt_q + 12'd1;
    if (vs_rise) y_cnt_d = '0;
    else if (href_fall && (y_cnt_q != CntMax)) y_cnt_d = y_cnt_q + 12'd1;
  end

  // Pixels coincident with vs_rise belong to the frame that state_d is entering.
  always_comb begin
`ifdef CMOS_CAP_CROP_EN
    y_pix  = vs_rise ? 12'd0 : y_cnt_q;
    in_win = ({1'b0, x_cnt_q} >= XLo) && ({1'b0, x_cnt_q} < XHi) &&
             ({1'b0, y_pix} >= YLo) && ({1'b0, y_pix} < YHi);
`else
    in_win = 1'b1;
`endif
    new_frame   = vs_rise && (state_d == StCapt);
    fwd         = frame_valid && (state_d == StCapt) && in_win;
    out_valid_d = fwd;
    out_data_d  = fwd ? frame_data : 16'd0;
    out_eol_d   = fwd && (x_cnt_q == LastCol);
    out_sof_d   = fwd && (new_frame || sof_pend_q);
    sof_pend_d  = sof_pend_q;
    if (state_d != StCapt) sof_pend_d = 1'b0;
    else if (fwd) sof_pend_d = 1'b0;
    else if (new_frame) sof_pend_d = 1'b1;
  end

  always_ff @(posedge cam_pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      vsync_q      <= 1'b0;
      href_q       <= 1'b0;
      x_cnt_q      <= '0;
      y_cnt_q      <= '0;
      single_q     <= 1'b0;
      skip_q       <= '0;
      skip_cnt_q   <= '0;
      stop_pend_q  <= 1'b0;
      sof_pend_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_sof_q    <= 1'b0;
      out_eol_q    <= 1'b0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
      err_line_q   <= 1'b0;
      err_frame_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      vsync_q      <= frame_vsync;
      href_q       <= frame_href;
      x_cnt_q      <= x_cnt_d;
      y_cnt_q      <= y_cnt_d;
      single_q     <= single_d;
      skip_q       <= skip_d;
      skip_cnt_q   <= skip_cnt_d;
      stop_pend_q  <= stop_pend_d;
      sof_pend_q   <= sof_pend_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_sof_q    <= out_sof_d;
      out_eol_q    <= out_eol_d;
      frame_done_q <= frame_done_d;
      frame_cnt_q  <= frame_cnt_d;
      err_line_q   <= err_line_d;
      err_frame_q  <= err_frame_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_sof    = out_sof_q;
  assign out_eol    = out_eol_q;
  assign frame_done = frame_done_q;
  assign busy       = (state_q != StIdle);
  assign frame_cnt  = frame_cnt_q;
  assign err_line   = err_line_q;
  assign err_frame  = err_frame_q;

endmodule

// File: tb/tb_cmos_capture_ctrl.sv
// Directed bench for cmos_capture_ctrl with an 8x4 frame geometry.
// With CMOS_CAP_CROP_EN defined only the reset and crop-window checks run.
module tb_cmos_capture_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        frame_vsync, frame_href, frame_valid;
  logic [15:0] frame_data;
  logic        cap_start, cap_stop, cap_single;
  logic [3:0]  frame_skip;
  logic        out_valid, out_sof, out_eol, frame_done, busy, err_line, err_frame;
  logic [15:0] out_data, frame_cnt;

  always #5 clk = ~clk;

  cmos_capture_ctrl #(
    .H_ACT   (8),
    .V_ACT   (4),
    .CROP_X0 (2),
    .CROP_Y0 (1),
    .CROP_W  (4),
    .CROP_H  (2)
  ) dut (
    .cam_pclk    (clk),
    .rst_n       (rst_n),
    .frame_vsync (frame_vsync),
    .frame_href  (frame_href),
    .frame_valid (frame_valid),
    .frame_data  (frame_data),
    .cap_start   (cap_start),
    .cap_stop    (cap_stop),
    .cap_single  (cap_single),
    .frame_skip  (frame_skip),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_sof     (out_sof),
    .out_eol     (out_eol),
    .frame_done  (frame_done),
    .busy        (busy),
    .frame_cnt   (frame_cnt),
    .err_line    (err_line),
    .err_frame   (err_frame)
  );

  int n_tests = 0;
  int n_fail  = 0;

  int          cnt_valid = 0, cnt_sof = 0, cnt_eol = 0, cnt_done = 0;
  logic [15:0] last_sof_data = '0, last_eol_data = '0;

  always @(negedge clk) begin
    if (out_valid) begin
      cnt_valid <= cnt_valid + 1;
      if (out_sof) begin
        cnt_sof       <= cnt_sof + 1;
        last_sof_data <= out_data;
      end
      if (out_eol) begin
        cnt_eol       <= cnt_eol + 1;
        last_eol_data <= out_data;
      end
    end
    if (frame_done) cnt_done <= cnt_done + 1;
  end

  logic start_req = 1'b0, stop_req = 1'b0;
  int   pix_in_frame = 0, line_in_frame = 0, stop_at = -1;
  int   s_valid, s_sof, s_eol, s_done;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic drive(input logic vs, input logic hr, input logic vl, input logic [15:0] d);
    @(negedge clk);
    frame_vsync = vs;
    frame_href  = hr;
    frame_valid = vl;
    frame_data  = d;
    cap_start   = start_req;
    cap_stop    = stop_req;
    start_req   = 1'b0;
    stop_req    = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0, 16'd0);
  endtask

  task automatic vs_pulse();
    pix_in_frame  = 0;
    line_in_frame = 0;
    drive(1'b1, 1'b0, 1'b0, 16'd0);
    drive(1'b1, 1'b0, 1'b0, 16'd0);
    idle(2);
  endtask

  task automatic send_line(input int npx);
    drive(1'b0, 1'b1, 1'b0, 16'd0);
    for (int p = 0; p < npx; p++) begin
      if (pix_in_frame == stop_at) stop_req = 1'b1;
      drive(1'b0, 1'b1, 1'b1, {4'hC, 6'(line_in_frame), 6'(p)});
      pix_in_frame++;
    end
    idle(2);
    line_in_frame++;
  endtask

  task automatic send_frame(input int nlines);
    vs_pulse();
    for (int l = 0; l < nlines; l++) send_line(8);
  endtask

  task automatic start(input logic single, input logic [3:0] skip);
    cap_single = single;
    frame_skip = skip;
    start_req  = 1'b1;
    idle(1);
  endtask

  task automatic snap();
    s_valid = cnt_valid;
    s_sof   = cnt_sof;
    s_eol   = cnt_eol;
    s_done  = cnt_done;
  endtask

  typedef struct {
    logic       single;
    logic [3:0] skip;
    int         nfr;
    int         exp_valid;
    int         exp_sof;
    int         exp_eol;
    int         exp_done;
    int         exp_cnt;
    int         exp_busy;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b1, 4'd0, 3, 32, 1, 4, 1, 1, 0};
    vecs[1] = '{1'b0, 4'd2, 7, 96, 3, 12, 3, 3, 1};
    vecs[2] = '{1'b0, 4'd0, 2, 64, 2, 8, 2, 2, 1};
    vecs[3] = '{1'b0, 4'd1, 3, 64, 2, 8, 2, 2, 1};
    vecs[4] = '{1'b1, 4'd5, 2, 32, 1, 4, 1, 1, 0};

    rst_n = 1'b0;
    frame_vsync = 0; frame_href = 0; frame_valid = 0; frame_data = '0;
    cap_start = 0; cap_stop = 0; cap_single = 0; frame_skip = '0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_out_sof", int'(out_sof), 0);
    check("rst_out_eol", int'(out_eol), 0);
    check("rst_frame_done", int'(frame_done), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_frame_cnt", int'(frame_cnt), 0);
    check("rst_err_line", int'(err_line), 0);
    check("rst_err_frame", int'(err_frame), 0);
    rst_n = 1'b1;
    idle(3);

`ifdef CMOS_CAP_CROP_EN
    start(1'b1, 4'd0);
    snap();
    send_frame(4);
    vs_pulse();
    idle(3);
    check("crop_valid", cnt_valid - s_valid, 8);
    check("crop_sof", cnt_sof - s_sof, 1);
    check("crop_eol", cnt_eol - s_eol, 2);
    check("crop_sof_data", int'(last_sof_data), 16'hC042);
    check("crop_eol_data", int'(last_eol_data), 16'hC085);
    check("crop_done", cnt_done - s_done, 1);
    check("crop_busy", int'(busy), 0);
`else
    // Table: start in the inter-frame gap, nfr frames, one closing vsync.
    for (int i = 0; i < 5; i++) begin
      start(vecs[i].single, vecs[i].skip);
      snap();
      for (int f = 0; f < vecs[i].nfr; f++) send_frame(4);
      vs_pulse();
      idle(3);
      check($sformatf("v%0d_valid", i), cnt_valid - s_valid, vecs[i].exp_valid);
      check($sformatf("v%0d_sof", i), cnt_sof - s_sof, vecs[i].exp_sof);
      check($sformatf("v%0d_eol", i), cnt_eol - s_eol, vecs[i].exp_eol);
      check($sformatf("v%0d_done", i), cnt_done - s_done, vecs[i].exp_done);
      check($sformatf("v%0d_frame_cnt", i), int'(frame_cnt), vecs[i].exp_cnt);
      check($sformatf("v%0d_busy", i), int'(busy), vecs[i].exp_busy);
      check($sformatf("v%0d_sof_data", i), int'(last_sof_data), 16'hC000);
      check($sformatf("v%0d_eol_data", i), int'(last_eol_data), 16'hC0C7);
      check($sformatf("v%0d_err", i), int'({err_line, err_frame}), 0);
      stop_req = 1'b1;
      idle(2);
      vs_pulse();
      idle(3);
      check($sformatf("v%0d_idle_after", i), int'(busy), 0);
    end

    // Start mid-frame 1: frame 2 is the single captured frame.
    vs_pulse();
    send_line(8);
    start(1'b1, 4'd0);
    snap();
    for (int l = 0; l < 3; l++) send_line(8);
    send_frame(4);
    send_frame(4);
    idle(3);
    check("ss_valid", cnt_valid - s_valid, 32);
    check("ss_done", cnt_done - s_done, 1);
    check("ss_frame_cnt", int'(frame_cnt), 1);
    check("ss_busy", int'(busy), 0);

    // Continuous skip=2: frame_cnt at the start of frame 7.
    start(1'b0, 4'd2);
    for (int f = 0; f < 6; f++) send_frame(4);
    vs_pulse();
    check("skip_cnt_at_f7", int'(frame_cnt), 2);
    stop_req = 1'b1;
    idle(2);
    vs_pulse();
    idle(3);

    // Stop mid-CAPT at pixel 10: frame completes.
    start(1'b0, 4'd0);
    snap();
    stop_at = 10;
    send_frame(4);
    stop_at = -1;
    check("stopc_busy_pending", int'(busy), 1);
    vs_pulse();
    idle(3);
    check("stopc_valid", cnt_valid - s_valid, 32);
    check("stopc_done", cnt_done - s_done, 1);
    check("stopc_frame_cnt", int'(frame_cnt), 1);
    check("stopc_busy", int'(busy), 0);

    // Stop while skipping: immediate return to idle, no output.
    start(1'b0, 4'd3);
    send_frame(4);
    vs_pulse();
    idle(2);
    snap();
    check("stops_busy_before", int'(busy), 1);
    send_line(8);
    stop_req = 1'b1;
    idle(1);
    idle(1);
    check("stops_busy_after", int'(busy), 0);
    send_line(8);
    send_frame(4);
    vs_pulse();
    idle(3);
    check("stops_valid", cnt_valid - s_valid, 0);
    check("stops_done", cnt_done - s_done, 0);

    // Bad geometry: short line, then short frame; flags sticky until next start.
    start(1'b0, 4'd0);
    vs_pulse();
    send_line(8);
    send_line(7);
    send_line(8);
    send_line(8);
    check("geom_err_line", int'(err_line), 1);
    check("geom_err_frame_early", int'(err_frame), 0);
    send_frame(3);
    vs_pulse();
    idle(2);
    check("geom_err_frame", int'(err_frame), 1);
    stop_req = 1'b1;
    idle(2);
    vs_pulse();
    idle(3);
    check("geom_busy", int'(busy), 0);
    check("geom_err_line_sticky", int'(err_line), 1);
    check("geom_err_frame_sticky", int'(err_frame), 1);
    start(1'b1, 4'd0);
    idle(1);
    check("geom_err_cleared", int'({err_line, err_frame}), 0);
    stop_req = 1'b1;
    idle(3);

    // Reset mid-CAPT: outputs drop at once, no frame_done; restart works.
    start(1'b0, 4'd0);
    snap();
    vs_pulse();
    send_line(8);
    drive(1'b0, 1'b1, 1'b0, 16'd0);
    for (int p = 0; p < 3; p++) drive(1'b0, 1'b1, 1'b1, {4'hC, 6'd1, 6'(p)});
    @(posedge clk);
    #1;
    check("rstm_valid_before", int'(out_valid), 1);
    rst_n = 1'b0;
    #1;
    check("rstm_valid", int'(out_valid), 0);
    check("rstm_data", int'(out_data), 0);
    check("rstm_busy", int'(busy), 0);
    check("rstm_frame_cnt", int'(frame_cnt), 0);
    @(negedge clk);
    frame_href = 1'b0;
    frame_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(3);
    check("rstm_no_done", cnt_done - s_done, 0);
    start(1'b1, 4'd0);
    snap();
    send_frame(4);
    vs_pulse();
    idle(3);
    check("rstm_restart_valid", cnt_valid - s_valid, 32);
    check("rstm_restart_done", cnt_done - s_done, 1);
    check("rstm_restart_cnt", int'(frame_cnt), 1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
